// File: rtl/rr_dispatch.sv
// Round-robin or externally steered 1-to-NumOut stream dispatcher with a one-entry register per output.
// Latency 1 cycle input-to-output; ready_o drops when the chosen target (or, in round robin, every target) is full.
// Optional per-output 16-bit dispatch counters: define GROVF_RR_DISPATCH_CNT_EN.
module rr_dispatch #(
    parameter int NumOut    = 4,
    parameter int DataWidth = 32,
    parameter bit ExtSel    = 1'b0,
    parameter int IdxWidth  = $clog2(NumOut)
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          flush_i,
    input  logic                          valid_i,
    output logic                          ready_o,
    input  logic [DataWidth-1:0]          data_i,
    input  logic [IdxWidth-1:0]           sel_i,
    output logic [NumOut-1:0]             valid_o,
    input  logic [NumOut-1:0]             ready_i,
    output logic [NumOut*DataWidth-1:0]   data_o,
    output logic [IdxWidth-1:0]           idx_o,
    output logic [NumOut*16-1:0]          cnt_o
);

    localparam int SelSpan = 1 << IdxWidth;

    logic [NumOut-1:0]    vld_q;
    logic [DataWidth-1:0] dat_q [NumOut];
    logic [IdxWidth-1:0]  rr_q;

    logic [NumOut-1:0]    free;
    logic [SelSpan-1:0]   free_pad;
    logic [IdxWidth-1:0]  rr_pick;
    logic                 rr_any;
    logic                 accept;
    logic [NumOut-1:0]    load;

    // A full slot whose consumer takes it this cycle can be refilled in the same cycle.
    assign free = ~vld_q | ready_i;

    // Out-of-range selects land on zero padding, so they stall instead of dropping.
    always_comb begin
        free_pad = '0;
        free_pad[NumOut-1:0] = free;
    end

    always_comb begin
        int cand;
        rr_any  = 1'b0;
        rr_pick = rr_q;
        cand    = 0;
        for (int off = 0; off < NumOut; off++) begin
            cand = int'(rr_q) + off;
            if (cand >= NumOut) begin
                cand = cand - NumOut;
            end
            if (!rr_any && free_pad[cand[IdxWidth-1:0]]) begin
                rr_any  = 1'b1;
                rr_pick = cand[IdxWidth-1:0];
            end
        end
    end

    always_comb begin
        if (ExtSel) begin
            idx_o   = sel_i;
            ready_o = free_pad[sel_i];
        end else begin
            idx_o   = rr_pick;
            ready_o = rr_any;
        end
    end

    assign accept = valid_i & ready_o;

    always_comb begin
        load = '0;
        for (int k = 0; k < NumOut; k++) begin
            load[k] = accept && (idx_o == IdxWidth'(k));
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_q <= '0;
            for (int k = 0; k < NumOut; k++) begin
                dat_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NumOut; k++) begin
                if (load[k]) begin
                    vld_q[k] <= 1'b1;
                    dat_q[k] <= data_i;
                end else if (ready_i[k]) begin
                    vld_q[k] <= 1'b0;
                end
            end
        end
    end

    // Flush wins over the post-accept pointer advance.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_q <= '0;
        end else if (flush_i) begin
            rr_q <= '0;
        end else if (!ExtSel && accept) begin
            rr_q <= (idx_o == IdxWidth'(NumOut - 1)) ? '0 : idx_o + IdxWidth'(1);
        end
    end

    assign valid_o = vld_q;

    always_comb begin
        data_o = '0;
        for (int k = 0; k < NumOut; k++) begin
            data_o[k*DataWidth +: DataWidth] = dat_q[k];
        end
    end

`ifdef GROVF_RR_DISPATCH_CNT_EN
    logic [15:0] cnt_q [NumOut];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int k = 0; k < NumOut; k++) begin
                cnt_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NumOut; k++) begin
                if (load[k]) begin
                    cnt_q[k] <= cnt_q[k] + 16'd1;
                end
            end
        end
    end

    always_comb begin
        cnt_o = '0;
        for (int k = 0; k < NumOut; k++) begin
            cnt_o[k*16 +: 16] = cnt_q[k];
        end
    end
`else
    assign cnt_o = '0;
`endif

endmodule

// File: tb/tb_rr_dispatch.sv
// Bench for rr_dispatch: round-robin 4-way, steered 4-way and steered 3-way instances share one stimulus.
module tb_rr_dispatch;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, flush, valid;
    logic [31:0] data;
    logic [1:0]  sel;
    logic [3:0]  ready;

    logic        ro0, ro1, ro2;
    logic [1:0]  io0, io1, io2;
    logic [3:0]  vo0, vo1;
    logic [2:0]  vo2;
    logic [127:0] d0, d1;
    logic [95:0] d2;
    logic [63:0] c0, c1;
    logic [47:0] c2;

    rr_dispatch #(.NumOut(4), .DataWidth(32), .ExtSel(1'b0)) u_rr (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .valid_i(valid), .ready_o(ro0),
        .data_i(data), .sel_i(sel), .valid_o(vo0), .ready_i(ready), .data_o(d0),
        .idx_o(io0), .cnt_o(c0));

    rr_dispatch #(.NumOut(4), .DataWidth(32), .ExtSel(1'b1)) u_ext (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .valid_i(valid), .ready_o(ro1),
        .data_i(data), .sel_i(sel), .valid_o(vo1), .ready_i(ready), .data_o(d1),
        .idx_o(io1), .cnt_o(c1));

    rr_dispatch #(.NumOut(3), .DataWidth(32), .ExtSel(1'b1)) u_ext3 (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .valid_i(valid), .ready_o(ro2),
        .data_i(data), .sel_i(sel), .valid_o(vo2), .ready_i(ready[2:0]), .data_o(d2),
        .idx_o(io2), .cnt_o(c2));

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: one pending beat per output slot plus a "next output to try" pointer.
    bit          mv   [3][4];
    logic [31:0] md   [3][4];
    int          mrr  [3];
    int          mcnt [3][4];

    function automatic int nof(input int i);
        return (i == 2) ? 3 : 4;
    endfunction

    function automatic bit extof(input int i);
        return i != 0;
    endfunction

    function automatic void choose(input int i, output bit rdy, output int idx);
        int n;
        n   = nof(i);
        rdy = 1'b0;
        if (extof(i)) begin
            idx = int'(sel);
            if (idx < n) rdy = !mv[i][idx] || ready[idx];
        end else begin
            idx = mrr[i];
            for (int off = 0; off < n; off++) begin
                int k;
                k = (mrr[i] + off) % n;
                if (!rdy && (!mv[i][k] || ready[k])) begin
                    rdy = 1'b1;
                    idx = k;
                end
            end
        end
    endfunction

    always @(posedge clk or posedge rst) begin : model
        bit r;
        int x;
        bit acc;
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                mrr[i] = 0;
                for (int k = 0; k < 4; k++) begin
                    mv[i][k] = 1'b0; md[i][k] = '0; mcnt[i][k] = 0;
                end
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                choose(i, r, x);
                acc = valid && r;
                for (int k = 0; k < nof(i); k++) begin
                    if (acc && k == x) begin
                        mv[i][k]   = 1'b1;
                        md[i][k]   = data;
                        mcnt[i][k] = (mcnt[i][k] + 1) & 16'hFFFF;
                    end else if (ready[k]) begin
                        mv[i][k] = 1'b0;
                    end
                end
                if (flush) mrr[i] = 0;
                else if (!extof(i) && acc) mrr[i] = (x + 1) % nof(i);
            end
        end
    end

    always @(negedge clk) begin : compare
        bit           r;
        int           x;
        logic         dr;
        logic [1:0]   di;
        logic [3:0]   dv, ev;
        logic [127:0] dd;
        logic [63:0]  dc, ec;
        for (int i = 0; i < 3; i++) begin
            choose(i, r, x);
            case (i)
                0: begin dr = ro0; di = io0; dv = vo0; dd = d0; dc = c0; end
                1: begin dr = ro1; di = io1; dv = vo1; dd = d1; dc = c1; end
                default: begin dr = ro2; di = io2; dv = {1'b0, vo2}; dd = {32'b0, d2}; dc = {16'b0, c2}; end
            endcase
            ev = '0;
            ec = '0;
            for (int k = 0; k < nof(i); k++) begin
                ev[k] = mv[i][k];
`ifdef GROVF_RR_DISPATCH_CNT_EN
                ec[k*16 +: 16] = 16'(mcnt[i][k]);
`endif
            end
            check($sformatf("i%0d ready_o", i), dr, r);
            if (valid) check($sformatf("i%0d idx_o", i), di, 64'(x));
            check($sformatf("i%0d valid_o", i), dv, ev);
            for (int k = 0; k < nof(i); k++) begin
                check($sformatf("i%0d data_o[%0d]", i, k), dd[k*32 +: 32], md[i][k]);
            end
            check($sformatf("i%0d cnt_o", i), dc, ec);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; valid = 1'b0; data = '0; sel = '0; ready = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset valid_o", vo0, 4'h0);
        check("reset data_o", d0, 128'h0);
        check("reset ready_o", ro0, 1'b1);
        check("reset cnt_o", c0, 64'h0);
        rst = 1'b0;

        // Sustained traffic, all consumers ready: strict 0,1,2,3 rotation.
        ready = 4'hF; valid = 1'b1; sel = 2'd0;
        for (int j = 0; j < 8; j++) begin
            data = 32'h10 + 32'(j);
            @(negedge clk);
            check("rot ready_o", ro0, 1'b1);
            check("rot idx_o", io0, 64'(j % 4));
            tick();
            check("rot valid_o", vo0, 64'(4'b0001 << (j % 4)));
            check("rot data", d0[(j % 4)*32 +: 32], 32'h10 + 32'(j));
        end
        valid = 1'b0;
`ifdef GROVF_RR_DISPATCH_CNT_EN
        check("rot cnt_o", c0, 64'h0002_0002_0002_0002);
`else
        check("rot cnt_o", c0, 64'h0);
`endif
        tick();

        // All consumers stalled: four beats fill the slots, the fifth waits for output 2.
        ready = 4'h0; valid = 1'b1;
        for (int j = 0; j < 5; j++) begin
            data = 32'h20 + 32'(j);
            @(negedge clk);
            if (j < 4) begin
                check("fill ready_o", ro0, 1'b1);
                check("fill idx_o", io0, 64'(j));
                tick();
            end else begin
                check("full ready_o", ro0, 1'b0);
            end
        end
        ready = 4'b0100;
        @(negedge clk);
        check("refill ready_o", ro0, 1'b1);
        check("refill idx_o", io0, 64'd2);
        tick();
        check("refill valid_o", vo0, 4'hF);
        check("refill data2", d0[95:64], 32'h24);
        check("held data0", d0[31:0], 32'h20);
        valid = 1'b0; ready = 4'hF;
        tick();

        // Steered mode: stall on a full target, then drain and refill in one cycle.
        sel = 2'd3; ready = 4'b0111; valid = 1'b1; data = 32'h30;
        @(negedge clk);
        check("ext ready_o", ro1, 1'b1);
        check("ext idx_o", io1, 64'd3);
        check("ext3 bad sel ready_o", ro2, 1'b0);
        tick();
        data = 32'h31;
        check("ext valid3", vo1[3], 1'b1);
        check("ext data3", d1[127:96], 32'h30);
        @(negedge clk);
        check("ext stall ready_o", ro1, 1'b0);
        tick();
        tick();
        check("ext hold data3", d1[127:96], 32'h30);
        check("ext hold valid3", vo1[3], 1'b1);
        check("ext3 bad sel ready_o", ro2, 1'b0);
        check("ext3 valid_o", vo2, 3'b000);
        ready = 4'hF;
        @(negedge clk);
        check("ext drain ready_o", ro1, 1'b1);
        tick();
        check("ext reload valid3", vo1[3], 1'b1);
        check("ext reload data3", d1[127:96], 32'h31);
        valid = 1'b0;
        tick();

        // Flush after two accepts; buffered beats survive, pointer restarts at 0.
        rst = 1'b1;
        tick();
        rst = 1'b0; sel = 2'd0; ready = 4'h0; valid = 1'b1; data = 32'h40;
        tick();
        data = 32'h41;
        tick();
        valid = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush keeps valid_o", vo0, 4'b0011);
        ready = 4'b0011; valid = 1'b1; data = 32'h42;
        @(negedge clk);
        check("post flush idx_o", io0, 64'd0);
        check("post flush ready_o", ro0, 1'b1);
        tick();
        valid = 1'b0;
        check("post flush valid_o", vo0, 4'b0001);
        check("post flush data0", d0[31:0], 32'h42);
        ready = 4'h0;
        #2 rst = 1'b1;
        #1;
        check("async reset valid_o", vo0, 4'h0);
        check("async reset ready_o", ro0, 1'b1);
        tick();
        rst = 1'b0;

`ifdef GROVF_RR_DISPATCH_CNT_EN
        sel = 2'd1; ready = 4'hF; valid = 1'b1;
        repeat (65537) tick();
        valid = 1'b0;
        check("cnt wrap ext", c1[31:16], 16'd1);
        check("cnt wrap ext3", c2[31:16], 16'd1);
        tick();
`endif

        for (int n = 0; n < 3000; n++) begin
            rst   = ($urandom_range(0, 199) == 0);
            flush = ($urandom_range(0, 19) == 0);
            valid = ($urandom_range(0, 3) != 0);
            data  = $urandom;
            sel   = 2'($urandom_range(0, 3));
            ready = 4'($urandom);
            tick();
        end
        rst = 1'b0; flush = 1'b0; valid = 1'b0; ready = 4'hF;
        repeat (2) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
